// File: rtl/ksa_pkg.sv
// Shared defaults and FSM encoding for the Kogge-Stone adder self-test engine.
package ksa_pkg;
  localparam int KSA_WIDTH  = 16;
  localparam int KSA_XBITS  = 10;
  localparam int KSA_YBITS  = 10;
  localparam int KSA_SETTLE = 1;

  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_RUN   = 2'd1;
  localparam state_t ST_DRAIN = 2'd2;
  localparam state_t ST_DONE  = 2'd3;
endpackage

// File: rtl/ksa_bist_if.sv
// Adder operand/result bus between the BIST engine (master) and the KSA (slave).
interface ksa_bist_if import ksa_pkg::*; #(
  parameter int WIDTH = KSA_WIDTH
);
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic [WIDTH-1:0] sum;
  logic             cout;

  modport master (output a, b, cin, input sum, cout);
  modport slave  (input a, b, cin, output sum, cout);
endinterface

// File: rtl/ksa_bist_dly.sv
// SETTLE-deep shift register pairing each driven vector with its sampled result.
module ksa_bist_dly import ksa_pkg::*; #(
  parameter int WIDTH  = KSA_WIDTH,
  parameter int SETTLE = KSA_SETTLE
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_clr,
  input  logic             i_vld,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_cin,
  output logic             o_vld,
  output logic [WIDTH-1:0] o_a,
  output logic [WIDTH-1:0] o_b,
  output logic             o_cin
);
  logic [SETTLE-1:0]            r_vld;
  logic [SETTLE-1:0]            r_cin;
  logic [SETTLE-1:0][WIDTH-1:0] r_a;
  logic [SETTLE-1:0][WIDTH-1:0] r_b;

  always_ff @(posedge clk) begin
    if (rst || i_clr) begin
      r_vld <= '0;
      r_cin <= '0;
      r_a   <= '0;
      r_b   <= '0;
    end else begin
      r_vld[0] <= i_vld;
      r_cin[0] <= i_cin;
      r_a[0]   <= i_a;
      r_b[0]   <= i_b;
      for (int s = 1; s < SETTLE; s++) begin
        r_vld[s] <= r_vld[s-1];
        r_cin[s] <= r_cin[s-1];
        r_a[s]   <= r_a[s-1];
        r_b[s]   <= r_b[s-1];
      end
    end
  end

  assign o_vld = r_vld[SETTLE-1];
  assign o_cin = r_cin[SETTLE-1];
  assign o_a   = r_a[SETTLE-1];
  assign o_b   = r_b[SETTLE-1];
endmodule

// File: rtl/ksa_bist.sv
// Exhaustive {A,B,Cin} sweep into an external KSA; checks {Cout,Sum} against a+b+cin
// and keeps pass/fail counts plus the first failing vector.
module ksa_bist import ksa_pkg::*; #(
  parameter int WIDTH  = KSA_WIDTH,
  parameter int XBITS  = KSA_XBITS,
  parameter int YBITS  = KSA_YBITS,
  parameter int SETTLE = KSA_SETTLE,
  parameter int CNT_W  = XBITS + YBITS + 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_start,
  input  logic             i_abort,
  ksa_bist_if.master       ksa,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_pass,
  output logic [CNT_W-1:0] o_num_correct,
  output logic [CNT_W-1:0] o_num_wrong,
  output logic             o_ff_valid,
  output logic [WIDTH-1:0] o_ff_a,
  output logic [WIDTH-1:0] o_ff_b,
  output logic             o_ff_cin
);
  localparam int IW = XBITS + YBITS + 1;
  localparam int DW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

  state_t           r_state, w_nxt;
  logic [IW-1:0]    r_idx, w_idx_nxt;
  logic [DW-1:0]    r_dcnt;
  logic [CNT_W-1:0] r_ok, r_bad;
  logic             r_ffv, r_ffc;
  logic [WIDTH-1:0] r_ffa, r_ffb;
  logic             w_last, w_launch, w_drive, w_chk, w_match;
  logic             w_dvld, w_dcin;
  logic [WIDTH-1:0] w_da, w_db;
  logic [WIDTH:0]   w_exp;

  assign w_last    = &r_idx;
  assign w_launch  = (r_state == ST_IDLE || r_state == ST_DONE) && i_start && !i_abort;
  assign w_drive   = w_launch || (r_state == ST_RUN && !w_last && !i_abort);
  assign w_idx_nxt = w_launch ? '0 : r_idx + IW'(1);

  // r_idx is {x,y,c}; the operand bus is a pure slice of that register
  assign ksa.a   = WIDTH'(r_idx[IW-1:YBITS+1]);
  assign ksa.b   = WIDTH'(r_idx[YBITS:1]);
  assign ksa.cin = r_idx[0];

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_nxt;
  end

  always_comb begin
    w_nxt = r_state;
    case (r_state)
      ST_IDLE, ST_DONE: if (i_abort) w_nxt = ST_IDLE; else if (i_start) w_nxt = ST_RUN;
      ST_RUN:           if (i_abort) w_nxt = ST_IDLE; else if (w_last) w_nxt = ST_DRAIN;
      ST_DRAIN:         if (i_abort) w_nxt = ST_IDLE;
                        else if (r_dcnt == DW'(SETTLE - 1)) w_nxt = ST_DONE;
      default:          w_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    o_busy = 1'b0;
    o_done = 1'b0;
    case (r_state)
      ST_RUN, ST_DRAIN: o_busy = 1'b1;
      ST_DONE:          o_done = 1'b1;
      default:          ;
    endcase
  end

  // Delay line is loaded with the same vector the operand bus takes at this edge
  ksa_bist_dly #(.WIDTH(WIDTH), .SETTLE(SETTLE)) u_dly (
    .clk   (clk),
    .rst   (rst),
    .i_clr (i_abort),
    .i_vld (w_drive),
    .i_a   (WIDTH'(w_idx_nxt[IW-1:YBITS+1])),
    .i_b   (WIDTH'(w_idx_nxt[YBITS:1])),
    .i_cin (w_idx_nxt[0]),
    .o_vld (w_dvld),
    .o_a   (w_da),
    .o_b   (w_db),
    .o_cin (w_dcin)
  );

  assign w_exp   = (WIDTH+1)'(w_da) + (WIDTH+1)'(w_db) + (WIDTH+1)'(w_dcin);
  assign w_match = ({ksa.cout, ksa.sum} == w_exp);
  assign w_chk   = w_dvld && !i_abort;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_idx  <= '0;
      r_dcnt <= '0;
      r_ok   <= '0;
      r_bad  <= '0;
      r_ffv  <= 1'b0;
      r_ffa  <= '0;
      r_ffb  <= '0;
      r_ffc  <= 1'b0;
    end else begin
      if (w_drive) r_idx <= w_idx_nxt;
      r_dcnt <= (r_state == ST_DRAIN) ? r_dcnt + DW'(1) : '0;
      if (w_launch) begin
        r_ok  <= '0;
        r_bad <= '0;
        r_ffv <= 1'b0;
        r_ffa <= '0;
        r_ffb <= '0;
        r_ffc <= 1'b0;
      end else if (w_chk) begin
        if (w_match) begin
          r_ok <= r_ok + CNT_W'(1);
        end else begin
          r_bad <= r_bad + CNT_W'(1);
          if (!r_ffv) begin
            r_ffv <= 1'b1;
            r_ffa <= w_da;
            r_ffb <= w_db;
            r_ffc <= w_dcin;
          end
        end
      end
    end
  end

  assign o_pass        = o_done && (r_bad == '0);
  assign o_num_correct = r_ok;
  assign o_num_wrong   = r_bad;
  assign o_ff_valid    = r_ffv;
  assign o_ff_a        = r_ffa;
  assign o_ff_b        = r_ffb;
  assign o_ff_cin      = r_ffc;
endmodule

// File: tb/tb_ksa_bist.sv
// Directed bench: 2-bit KSA model with injectable faults and a SETTLE-1 deep output pipe.
module tb_ksa_bist;
  import ksa_pkg::*;
  localparam int W  = 2;
  localparam int XB = 2;
  localparam int YB = 2;
  localparam int ST = 3;
  localparam int CW = XB + YB + 2;
  localparam int N  = 1 << (XB + YB + 1);

  typedef struct packed {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         c;
  } vec_t;

  logic clk = 1'b0, rst = 1'b1, start = 1'b0, abort = 1'b0;
  logic busy, done, pass, ffv, ffc;
  logic [CW-1:0] nok, nbad;
  logic [W-1:0]  ffa, ffb;
  logic [W:0]    p1, p2;
  int   fault = 0;
  int   total = 0;
  int   bad   = 0;
  vec_t sbq[$];

  ksa_bist_if #(.WIDTH(W)) bus ();

  ksa_bist #(.WIDTH(W), .XBITS(XB), .YBITS(YB), .SETTLE(ST), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .i_start(start), .i_abort(abort), .ksa(bus),
    .o_busy(busy), .o_done(done), .o_pass(pass),
    .o_num_correct(nok), .o_num_wrong(nbad),
    .o_ff_valid(ffv), .o_ff_a(ffa), .o_ff_b(ffb), .o_ff_cin(ffc)
  );

  always #5 clk = ~clk;

  // fault 1: Sum[0] stuck at 0; fault 2: Cout stuck at 0
  function automatic logic [W:0] ksa_model(logic [W-1:0] a, logic [W-1:0] b, logic c, int f);
    logic [W:0] s;
    s = (W+1)'(a) + (W+1)'(b) + (W+1)'(c);
    if (f == 1) s[0] = 1'b0;
    if (f == 2) s[W] = 1'b0;
    return s;
  endfunction

  always @(posedge clk) begin
    p1 <= ksa_model(bus.a, bus.b, bus.cin, fault);
    p2 <= p1;
  end
  assign {bus.cout, bus.sum} = p2;

  function automatic vec_t vec_of(int k);
    vec_t v;
    v.c = k[0];
    v.b = W'((k >> 1) & ((1 << YB) - 1));
    v.a = W'(k >> (YB + 1));
    return v;
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0d, want %0d", tag, obs, exp);
    end
  endtask

  task automatic run_full(input int f, input int e_ok, input int e_bad, input int e_pass,
                          input int e_ffv, input int e_ffa, input int e_ffb, input int e_ffc);
    int   nb;
    int   guard;
    vec_t e;
    fault = f;
    for (int k = 0; k < N; k++) sbq.push_back(vec_of(k));
    start = 1'b1;
    tick;
    start = 1'b0;
    chk("launch_ok_clr", nok, 0);
    chk("launch_bad_clr", nbad, 0);
    chk("launch_ffv_clr", ffv, 0);
    chk("launch_done_clr", done, 0);
    nb = 0;
    for (int k = 0; k < N; k++) begin
      e = sbq.pop_front();
      chk($sformatf("vec%0d", k), {bus.a, bus.b, bus.cin}, e);
      if (busy) nb++;
      tick;
    end
    guard = 0;
    while (busy && guard < 64) begin
      nb++;
      guard++;
      tick;
    end
    chk("busy_cycles", nb, N + ST);
    chk("sb_empty", sbq.size(), 0);
    chk("done", done, 1);
    chk("num_correct", nok, e_ok);
    chk("num_wrong", nbad, e_bad);
    chk("pass", pass, e_pass);
    chk("ff_valid", ffv, e_ffv);
    chk("ff_a", ffa, e_ffa);
    chk("ff_b", ffb, e_ffb);
    chk("ff_cin", ffc, e_ffc);
  endtask

  initial begin
    vec_t e;
    rst = 1'b1;
    tick;
    tick;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_pass", pass, 0);
    chk("rst_ok", nok, 0);
    chk("rst_bad", nbad, 0);
    chk("rst_ffv", ffv, 0);
    chk("rst_bus", {bus.a, bus.b, bus.cin}, 0);
    rst = 1'b0;
    tick;

    start = 1'b1;
    abort = 1'b1;
    tick;
    start = 1'b0;
    abort = 1'b0;
    chk("start_abort_busy", busy, 0);
    chk("start_abort_done", done, 0);

    run_full(0, 32, 0, 1, 0, 0, 0, 0);
    run_full(1, 16, 16, 0, 1, 0, 0, 1);
    run_full(2, 16, 16, 0, 1, 0, 3, 1);

    // start mid-run is ignored, abort discards the rest
    fault = 0;
    start = 1'b1;
    tick;
    start = 1'b0;
    repeat (10) tick;
    e = vec_of(10);
    chk("vec10", {bus.a, bus.b, bus.cin}, e);
    start = 1'b1;
    tick;
    start = 1'b0;
    e = vec_of(11);
    chk("ign_start_vec", {bus.a, bus.b, bus.cin}, e);
    chk("ign_start_busy", busy, 1);
    abort = 1'b1;
    tick;
    abort = 1'b0;
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_ok_range", (nok >= 5 && nok <= 10), 1);
    chk("abort_bad", nbad, 0);
    repeat (3) tick;
    chk("abort_hold_busy", busy, 0);
    chk("abort_hold_ok", (nok >= 5 && nok <= 10), 1);
    chk("abort_hold_bad", nbad, 0);

    run_full(0, 32, 0, 1, 0, 0, 0, 0);

    // reset mid-run with a first-fail already captured
    fault = 1;
    start = 1'b1;
    tick;
    start = 1'b0;
    repeat (5) tick;
    e = vec_of(5);
    chk("vec5", {bus.a, bus.b, bus.cin}, e);
    chk("pre_rst_ffv", ffv, 1);
    rst = 1'b1;
    tick;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_done", done, 0);
    chk("mid_rst_ok", nok, 0);
    chk("mid_rst_bad", nbad, 0);
    chk("mid_rst_ffv", ffv, 0);
    chk("mid_rst_ff", {ffa, ffb, ffc}, 0);
    chk("mid_rst_bus", {bus.a, bus.b, bus.cin}, 0);
    rst = 1'b0;
    tick;

    run_full(0, 32, 0, 1, 0, 0, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
